// File: rtl/ctrl_bcast_pkg.sv
// Shared frame constants, FSM state encoding and check-byte function for ctrl_bcast_tx.
// Define CTRL_CRC8_EN to switch the check byte from a mod-256 sum to CRC-8 (poly 0x07).
package ctrl_bcast_pkg;

    localparam int FRAME_BITS   = 42;
    localparam int PAYLOAD_BITS = 32;
    localparam int CHK_BITS     = 8;

    localparam logic [CHK_BITS-1:0] CRC_POLY  = 8'h07;
    localparam logic                LINE_IDLE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_CHK,
        ST_STOP,
        ST_GAP
    } state_e;

    function automatic logic [CHK_BITS-1:0] calc_chk(input logic [PAYLOAD_BITS-1:0] w);
        logic [CHK_BITS-1:0] c;
`ifdef CTRL_CRC8_EN
        // Bit-serial CRC over the payload, MSB first, no reflection or final XOR.
        c = '0;
        for (int i = PAYLOAD_BITS - 1; i >= 0; i--) begin
            if (c[CHK_BITS-1] ^ w[i]) c = {c[CHK_BITS-2:0], 1'b0} ^ CRC_POLY;
            else                      c = {c[CHK_BITS-2:0], 1'b0};
        end
`else
        c = w[31:24] + w[23:16] + w[15:8] + w[7:0];
`endif
        return c;
    endfunction

endpackage

// File: rtl/ctrl_cmd_fifo.sv
// Synchronous command FIFO; pointers carry an extra wrap bit for full/empty.
// Simultaneous push and pop are both honoured.
module ctrl_cmd_fifo
    import ctrl_bcast_pkg::*;
#(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk_sys,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count   = wr_ptr_q - rd_ptr_q;
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk_sys) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/ctrl_bcast_tx.sv
// Multi-lane RS-485 control broadcaster: queued commands become framed serial bursts, plus GPS sync pulses.
// Optional build macro CTRL_CRC8_EN selects a CRC-8 check byte instead of the byte sum.
module ctrl_bcast_tx
    import ctrl_bcast_pkg::*;
#(
    parameter int NCH        = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int BIT_DIV    = 100,
    parameter int SYN_W      = 10,
    parameter int GAP_BITS   = 2
) (
    input  logic           clk_sys,
    input  logic           rst_n,
    input  logic [7:0]     dev_id,
    input  logic [7:0]     mod_id,
    input  logic [7:0]     cmd_addr,
    input  logic [7:0]     cmd_data,
    input  logic           cmd_vld,
    output logic           cmd_rdy,
    input  logic [NCH-1:0] ch_mask,
    input  logic           gps_pluse,
    output logic [NCH-1:0] tx_ctrl,
    output logic [NCH-1:0] tx_syn,
    output logic           busy,
    output logic           ovf
);

    localparam int SH_W  = FRAME_BITS - 2;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int DIV_W = $clog2(BIT_DIV);
    localparam int SCW   = $clog2(SYN_W + 1);

    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
    // The last gap bit is cut two cycles short so IDLE+LOAD complete the gap exactly.
    localparam logic [DIV_W-1:0] GAP_LAST = DIV_W'(BIT_DIV - 3);
    localparam logic [5:0]       BIT_ONE  = 6'd1;
    localparam logic [SCW-1:0]   SYN_ONE  = SCW'(1);

    if (NCH < 1 || NCH > 16) begin : g_chk_nch
        $error("NCH out of range");
    end
    if (BIT_DIV < 4) begin : g_chk_div
        $error("BIT_DIV must be at least 4");
    end
    if (GAP_BITS < 1) begin : g_chk_gap
        $error("GAP_BITS must be at least 1");
    end

    // Command queue
    logic [31:0]      fifo_rd_data;
    logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [CNT_W-1:0] fifo_cnt;
    logic             rdy_en_q, rdy_en_d;
    logic             ovf_q, ovf_d;

    assign cmd_rdy   = rdy_en_q && !fifo_full;
    assign fifo_push = cmd_vld && cmd_rdy;
    assign ovf       = ovf_q;

    ctrl_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PAYLOAD_BITS)
    ) u_fifo (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .wr_data ({dev_id, mod_id, cmd_addr, cmd_data}),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_cnt)
    );

    always_comb begin
        rdy_en_d = 1'b1;
        ovf_d    = ovf_q || (cmd_vld && fifo_full);
    end

    // Frame FSM
    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d, div_nxt;
    logic [5:0]       bit_q, bit_d;
    logic [SH_W-1:0]  sh_q, sh_d;
    logic [NCH-1:0]   mask_q, mask_d;
    logic             bit_end;

    assign bit_end = (div_q == DIV_LAST);
    assign div_nxt = bit_end ? '0 : div_q + DIV_ONE;
    assign busy    = (state_q != ST_IDLE) || (fifo_cnt != '0);

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        sh_d     = sh_q;
        mask_d   = mask_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                div_d = '0;
                bit_d = '0;
                if (!fifo_empty) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                fifo_pop = 1'b1;
                sh_d     = {fifo_rd_data, calc_chk(fifo_rd_data)};
                mask_d   = ch_mask;
                div_d    = '0;
                bit_d    = '0;
                state_d  = ST_START;
            end
            ST_START: begin
                div_d = div_nxt;
                if (bit_end) state_d = ST_DATA;
            end
            ST_DATA: begin
                div_d = div_nxt;
                if (bit_end) begin
                    sh_d  = {sh_q[SH_W-2:0], 1'b0};
                    bit_d = bit_q + BIT_ONE;
                    if (bit_q == 6'(PAYLOAD_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = ST_CHK;
                    end
                end
            end
            ST_CHK: begin
                div_d = div_nxt;
                if (bit_end) begin
                    sh_d  = {sh_q[SH_W-2:0], 1'b0};
                    bit_d = bit_q + BIT_ONE;
                    if (bit_q == 6'(CHK_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                div_d = div_nxt;
                if (bit_end) begin
                    bit_d   = '0;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                div_d = div_nxt;
                if (bit_q == 6'(GAP_BITS - 1) && div_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else if (bit_end) begin
                    bit_d = bit_q + BIT_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Lane drivers: registered so the line lags the state by one cycle.
    logic           ser_bit;
    logic [NCH-1:0] tx_ctrl_q, tx_ctrl_d;

    always_comb begin
        ser_bit = LINE_IDLE;
        if (state_q == ST_START)                          ser_bit = 1'b0;
        else if (state_q == ST_DATA || state_q == ST_CHK) ser_bit = sh_q[SH_W-1];
        for (int i = 0; i < NCH; i++) begin
            tx_ctrl_d[i] = mask_q[i] ? ser_bit : LINE_IDLE;
        end
    end

    assign tx_ctrl = tx_ctrl_q;

    // Sync path: 2-flop synchroniser, rising-edge detect, retriggerable pulse.
    logic           gps_meta_q, gps_sync_q, gps_dly_q;
    logic           gps_rise;
    logic [SCW-1:0] syn_cnt_q, syn_cnt_d;
    logic [NCH-1:0] syn_mask_q, syn_mask_d;

    assign gps_rise = gps_sync_q && !gps_dly_q;

    always_comb begin
        syn_cnt_d  = syn_cnt_q;
        syn_mask_d = syn_mask_q;
        if (gps_rise) begin
            syn_cnt_d  = SCW'(SYN_W);
            syn_mask_d = ch_mask;
        end else if (syn_cnt_q != '0) begin
            syn_cnt_d = syn_cnt_q - SYN_ONE;
        end
    end

    assign tx_syn = (syn_cnt_q != '0) ? syn_mask_q : '0;

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            bit_q      <= '0;
            sh_q       <= '0;
            mask_q     <= '0;
            tx_ctrl_q  <= {NCH{LINE_IDLE}};
            rdy_en_q   <= 1'b0;
            ovf_q      <= 1'b0;
            gps_meta_q <= 1'b0;
            gps_sync_q <= 1'b0;
            gps_dly_q  <= 1'b0;
            syn_cnt_q  <= '0;
            syn_mask_q <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            sh_q       <= sh_d;
            mask_q     <= mask_d;
            tx_ctrl_q  <= tx_ctrl_d;
            rdy_en_q   <= rdy_en_d;
            ovf_q      <= ovf_d;
            gps_meta_q <= gps_pluse;
            gps_sync_q <= gps_meta_q;
            gps_dly_q  <= gps_sync_q;
            syn_cnt_q  <= syn_cnt_d;
            syn_mask_q <= syn_mask_d;
        end
    end

endmodule

// File: tb/tb_ctrl_bcast_tx.sv
// Directed bench for ctrl_bcast_tx: table of single-frame vectors plus burst, sync and reset sequences.
module tb_ctrl_bcast_tx;

    localparam int NCH        = 2;
    localparam int FIFO_DEPTH = 8;
    localparam int BIT_DIV    = 100;
    localparam int SYN_W      = 10;
    localparam int GAP_BITS   = 2;

    logic           clk_sys = 1'b0;
    logic           rst_n   = 1'b0;
    logic [7:0]     dev_id  = '0, mod_id = '0, cmd_addr = '0, cmd_data = '0;
    logic           cmd_vld = 1'b0;
    logic           cmd_rdy;
    logic [NCH-1:0] ch_mask = '1;
    logic           gps_pluse = 1'b0;
    logic [NCH-1:0] tx_ctrl, tx_syn;
    logic           busy, ovf;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    ctrl_bcast_tx #(
        .NCH        (NCH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .BIT_DIV    (BIT_DIV),
        .SYN_W      (SYN_W),
        .GAP_BITS   (GAP_BITS)
    ) dut (
        .clk_sys   (clk_sys),
        .rst_n     (rst_n),
        .dev_id    (dev_id),
        .mod_id    (mod_id),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .cmd_vld   (cmd_vld),
        .cmd_rdy   (cmd_rdy),
        .ch_mask   (ch_mask),
        .gps_pluse (gps_pluse),
        .tx_ctrl   (tx_ctrl),
        .tx_syn    (tx_syn),
        .busy      (busy),
        .ovf       (ovf)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0]    w;
        logic [NCH-1:0] mask;
        logic [NCH-1:0] mid;
        logic [7:0]     sum;
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_chk(input logic [31:0] w);
        logic [7:0] c;
`ifdef CTRL_CRC8_EN
        c = 8'h00;
        for (int k = 3; k >= 0; k--) begin
            c = c ^ w[8*k +: 8];
            for (int j = 0; j < 8; j++) c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
`else
        c = w[31:24] + w[23:16] + w[15:8] + w[7:0];
`endif
        return c;
    endfunction

    function automatic logic [41:0] frame_of(input logic [31:0] w, input logic [7:0] c);
        return {1'b0, w, c, 1'b1};
    endfunction

    task automatic push_cmd(input logic [31:0] w);
        {dev_id, mod_id, cmd_addr, cmd_data} = w;
        cmd_vld = 1'b1;
        tick();
        cmd_vld = 1'b0;
    endtask

    // Called just after the edge where the start bit appeared; samples every bit mid-cell.
    task automatic sample_frame(input logic [NCH-1:0] mid, output logic [NCH-1:0][41:0] fr);
        fr = '1;
        repeat (BIT_DIV / 2) tick();
        for (int b = 0; b < 42; b++) begin
            for (int i = 0; i < NCH; i++) fr[i][41-b] = tx_ctrl[i];
            if (b == 10) ch_mask = mid;
            if (b < 41) repeat (BIT_DIV) tick();
        end
    endtask

    task automatic capture(input int bound, output bit ok, output int t0,
                           output logic [NCH-1:0][41:0] fr);
        ok = 1'b0;
        t0 = 0;
        fr = '1;
        for (int k = 0; k < bound && !ok; k++) begin
            tick();
            if (tx_ctrl != '1) ok = 1'b1;
        end
        if (ok) begin
            t0 = cyc;
            sample_frame(ch_mask, fr);
        end
    endtask

    initial begin
        logic [NCH-1:0][41:0] fr;
        logic [5:0]           lat;
        logic [7:0]           c;
        logic [31:0]          bw[10];
        logic [41:0]          ef;
        bit                   ok;
        int                   t0, tprev, tx_push, bad;

        vecs[0] = '{32'h01021055, 2'b11, 2'b11, 8'h68};
        vecs[1] = '{32'hFFFFFFFF, 2'b11, 2'b11, 8'hFC};
        vecs[2] = '{32'hA5003CC3, 2'b01, 2'b10, 8'hA4};
        vecs[3] = '{32'h00000000, 2'b00, 2'b11, 8'h00};
        vecs[4] = '{32'h80010203, 2'b10, 2'b01, 8'h86};

        // Reset state
        repeat (3) tick();
        chk("rst_cmd_rdy", 64'(cmd_rdy), 64'd0);
        chk("rst_tx_ctrl", 64'(tx_ctrl), 64'h3);
        chk("rst_tx_syn",  64'(tx_syn),  64'h0);
        chk("rst_busy",    64'(busy),    64'd0);
        chk("rst_ovf",     64'(ovf),     64'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_cmd_rdy", 64'(cmd_rdy), 64'd1);

        // Single-frame vectors
        for (int n = 0; n < 5; n++) begin
`ifdef CTRL_CRC8_EN
            c = exp_chk(vecs[n].w);
`else
            c = vecs[n].sum;
`endif
            ch_mask = vecs[n].mask;
            push_cmd(vecs[n].w);
            for (int k = 0; k < 3; k++) begin
                lat[2*(2-k) +: 2] = tx_ctrl;
                if (k < 2) tick();
            end
            tick();
            lat[1:0] = tx_ctrl;
            chk($sformatf("latency_v%0d", n), 64'(lat), 64'({2'b11, 2'b11, ~vecs[n].mask}));
            sample_frame(vecs[n].mid, fr);
            for (int i = 0; i < NCH; i++) begin
                ef = vecs[n].mask[i] ? frame_of(vecs[n].w, c) : '1;
                chk($sformatf("frame_v%0d_l%0d", n, i), 64'(fr[i]), 64'(ef));
            end
            repeat (246) tick();
            chk($sformatf("busy_end_v%0d", n), 64'(busy), 64'd1);
            tick();
            chk($sformatf("idle_v%0d", n), 64'(busy), 64'd0);
        end

        // GPS sync pulse with retrigger and live mask sampling
        ch_mask = 2'b10;
        tick();
        gps_pluse = 1'b1;
        bad = 0;
        for (int k = 1; k <= 20; k++) begin
            logic [NCH-1:0] es;
            tick();
            es = (k >= 3 && k <= 7) ? 2'b10 : (k >= 8 && k <= 17) ? 2'b01 : 2'b00;
            if (tx_syn !== es) begin
                bad++;
                $display("FAIL syn_k%0d: got %b, expected %b", k, tx_syn, es);
            end
            if (k == 2) gps_pluse = 1'b0;
            if (k == 5) begin
                gps_pluse = 1'b1;
                ch_mask   = 2'b01;
            end
        end
        chk("syn_sequence_errors", 64'(bad), 64'd0);
        gps_pluse = 1'b0;

        // Burst: FIFO fills behind a frame in flight, two commands dropped
        chk("ovf_before_burst", 64'(ovf), 64'd0);
        ch_mask = 2'b11;
        push_cmd(32'h11223344);
        tx_push = cyc;
        repeat (8) tick();
        for (int j = 0; j < 10; j++) begin
            bw[j] = {8'(j), 8'hC3, 8'(3 * j), 8'h5A};
            {dev_id, mod_id, cmd_addr, cmd_data} = bw[j];
            cmd_vld = 1'b1;
            tick();
            chk($sformatf("burst_rdy_%0d", j), 64'(cmd_rdy), 64'(j < 7));
            chk($sformatf("burst_ovf_%0d", j), 64'(ovf), 64'(j >= 8));
        end
        cmd_vld = 1'b0;
        while (cyc < tx_push + 4390) tick();
        tprev = 0;
        for (int f = 0; f < 8; f++) begin
            capture(4500, ok, t0, fr);
            chk($sformatf("burst_seen_%0d", f), 64'(ok), 64'd1);
            if (f == 0) chk("burst_first_start", 64'(t0 - tx_push), 64'd4403);
            else        chk($sformatf("burst_spacing_%0d", f), 64'(t0 - tprev), 64'd4400);
            tprev = t0;
            ef = frame_of(bw[f], exp_chk(bw[f]));
            chk($sformatf("burst_frame_%0d", f), 64'({fr[1], fr[0]} == {ef, ef}), 64'd1);
        end
        capture(5000, ok, t0, fr);
        chk("burst_no_extra_frame", 64'(ok), 64'd0);
        chk("burst_idle", 64'(busy), 64'd0);

        // Reset in the middle of the payload
        push_cmd(32'h00000001);
        tx_push = cyc;
        push_cmd(32'hAA55AA55);
        while (cyc < tx_push + 453) tick();
        chk("mid_data_line_low", 64'(tx_ctrl), 64'h0);
        chk("mid_data_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_tx_ctrl", 64'(tx_ctrl), 64'h3);
        chk("mid_rst_busy",    64'(busy),    64'd0);
        chk("mid_rst_cmd_rdy", 64'(cmd_rdy), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_mid_rst_rdy", 64'(cmd_rdy), 64'd1);
        chk("post_mid_rst_ovf", 64'(ovf),     64'd0);
        bad = 0;
        for (int k = 0; k < 4500; k++) begin
            tick();
            if (tx_ctrl !== 2'b11 || busy !== 1'b0) bad++;
        end
        chk("no_resume_after_rst", 64'(bad), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
